// File: rtl/uart_alu_frame_ctrl_if.sv
// -----------------------------------------------------------------------------
// uart_alu_frame_ctrl_if
// Bundles the receive, transmit and ALU signals of the frame controller.
//   i_rx_done / i_data           : received-byte strobe and byte
//   i_tx_active / i_tx_done      : transmitter busy level and byte-done strobe
//   i_alu_result                 : combinational ALU result
//   o_tx_start_bit / o_tx_byte   : transmit request strobe and byte
//   o_data_A/B/OPCODE            : operands and opcode presented to the ALU
//   o_busy / o_err_timeout / o_overrun : status
// modport master : the frame controller
// modport slave  : the UART pair and ALU around it
// -----------------------------------------------------------------------------
interface uart_alu_frame_ctrl_if #(
   parameter int DATA_W = 16,
   parameter int OP_W   = 6
);
   logic              i_rx_done;
   logic [7:0]        i_data;
   logic              i_tx_active;
   logic              i_tx_done;
   logic [DATA_W-1:0] i_alu_result;
   logic              o_tx_start_bit;
   logic [7:0]        o_tx_byte;
   logic [DATA_W-1:0] o_data_A;
   logic [DATA_W-1:0] o_data_B;
   logic [OP_W-1:0]   o_data_OPCODE;
   logic              o_busy;
   logic              o_err_timeout;
   logic              o_overrun;

   modport master (
      input  i_rx_done, i_data, i_tx_active, i_tx_done, i_alu_result,
      output o_tx_start_bit, o_tx_byte, o_data_A, o_data_B, o_data_OPCODE,
             o_busy, o_err_timeout, o_overrun
   );

   modport slave (
      output i_rx_done, i_data, i_tx_active, i_tx_done, i_alu_result,
      input  o_tx_start_bit, o_tx_byte, o_data_A, o_data_B, o_data_OPCODE,
             o_busy, o_err_timeout, o_overrun
   );
endinterface

// File: rtl/uart_alu_frame_ctrl.sv
// -----------------------------------------------------------------------------
// uart_alu_frame_ctrl
// Assembles a frame of NB bytes of A, NB bytes of B (both LSB first) and one
// opcode byte from the UART receiver, publishes all three to the ALU in one
// clock edge, then returns the NB-byte ALU result LSB first via the transmitter.
// A stalled partial frame is discarded after TIMEOUT idle clocks; bytes that
// arrive while a result is being computed or sent are dropped and flagged.
// Ports:
//   i_Clock : clock, rising edge
//   i_reset : synchronous active-low reset
//   bus     : uart_alu_frame_ctrl_if.master (receive/transmit/ALU/status)
// -----------------------------------------------------------------------------
module uart_alu_frame_ctrl #(
   parameter int DATA_W  = 16,
   parameter int OP_W    = 6,
   parameter int TIMEOUT = 50000
) (
   input logic                   i_Clock,
   input logic                   i_reset,
   uart_alu_frame_ctrl_if.master bus
);
   localparam int NB    = DATA_W / 8;
   localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      IDLE, RX_A, RX_B, RX_OP, EXEC, TX_SEND, TX_WAIT
   } state_t;

   state_t            state_q;
   logic [IDX_W-1:0]  idx_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [DATA_W-1:0] shadow_a_q;
   logic [DATA_W-1:0] shadow_b_q;
   logic [DATA_W-1:0] res_q;
   logic [DATA_W-1:0] data_a_q;
   logic [DATA_W-1:0] data_b_q;
   logic [OP_W-1:0]   opcode_q;
   logic              start_q;
   logic [7:0]        tx_byte_q;
   logic              err_q;
   logic              ovr_q;

   logic in_rx;
   logic in_out;
   logic last_idx;
   logic timeout_hit;

   assign in_rx       = (state_q == RX_A) || (state_q == RX_B) || (state_q == RX_OP);
   assign in_out      = (state_q == EXEC) || (state_q == TX_SEND) || (state_q == TX_WAIT);
   assign last_idx    = (idx_q == IDX_W'(NB - 1));
   // Counter holds the number of idle edges already seen, so the abort lands
   // exactly TIMEOUT edges after the last accepted byte.
   assign timeout_hit = in_rx && !bus.i_rx_done && (cnt_q == CNT_W'(TIMEOUT - 1));

   always_ff @(posedge i_Clock) begin
      if (!i_reset) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         cnt_q      <= '0;
         shadow_a_q <= '0;
         shadow_b_q <= '0;
         res_q      <= '0;
         data_a_q   <= '0;
         data_b_q   <= '0;
         opcode_q   <= '0;
         start_q    <= 1'b0;
         tx_byte_q  <= '0;
         err_q      <= 1'b0;
         ovr_q      <= 1'b0;
      end else begin
         start_q <= 1'b0;
         err_q   <= 1'b0;
         ovr_q   <= bus.i_rx_done && in_out;

         if (bus.i_rx_done || !in_rx)
            cnt_q <= '0;
         else
            cnt_q <= cnt_q + 1'b1;

         if (timeout_hit) begin
            err_q      <= 1'b1;
            idx_q      <= '0;
            shadow_a_q <= '0;
            shadow_b_q <= '0;
            cnt_q      <= '0;
            state_q    <= IDLE;
         end else begin
            case (state_q)
               IDLE: begin
                  if (bus.i_rx_done) begin
                     shadow_a_q[7:0] <= bus.i_data;
                     if (NB == 1) begin
                        idx_q   <= '0;
                        state_q <= RX_B;
                     end else begin
                        idx_q   <= IDX_W'(1);
                        state_q <= RX_A;
                     end
                  end
               end
               RX_A: begin
                  if (bus.i_rx_done) begin
                     shadow_a_q[{idx_q, 3'b000} +: 8] <= bus.i_data;
                     if (last_idx) begin
                        idx_q   <= '0;
                        state_q <= RX_B;
                     end else begin
                        idx_q <= idx_q + 1'b1;
                     end
                  end
               end
               RX_B: begin
                  if (bus.i_rx_done) begin
                     shadow_b_q[{idx_q, 3'b000} +: 8] <= bus.i_data;
                     if (last_idx) begin
                        idx_q   <= '0;
                        state_q <= RX_OP;
                     end else begin
                        idx_q <= idx_q + 1'b1;
                     end
                  end
               end
               RX_OP: begin
                  // Operands and opcode move together so the ALU never sees
                  // a mix of old and new frame contents.
                  if (bus.i_rx_done) begin
                     data_a_q <= shadow_a_q;
                     data_b_q <= shadow_b_q;
                     opcode_q <= bus.i_data[OP_W-1:0];
                     state_q  <= EXEC;
                  end
               end
               EXEC: begin
                  res_q   <= bus.i_alu_result;
                  idx_q   <= '0;
                  state_q <= TX_SEND;
               end
               TX_SEND: begin
                  if (!bus.i_tx_active) begin
                     start_q   <= 1'b1;
                     tx_byte_q <= res_q[7:0];
                     state_q   <= TX_WAIT;
                  end
               end
               TX_WAIT: begin
                  if (bus.i_tx_done) begin
                     // Shift so the next byte to send is always in the low lane.
                     res_q <= res_q >> 8;
                     if (last_idx) begin
                        idx_q   <= '0;
                        state_q <= IDLE;
                     end else begin
                        idx_q   <= idx_q + 1'b1;
                        state_q <= TX_SEND;
                     end
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign bus.o_tx_start_bit = start_q;
   assign bus.o_tx_byte      = tx_byte_q;
   assign bus.o_data_A       = data_a_q;
   assign bus.o_data_B       = data_b_q;
   assign bus.o_data_OPCODE  = opcode_q;
   assign bus.o_busy         = (state_q != IDLE);
   assign bus.o_err_timeout  = err_q;
   assign bus.o_overrun      = ovr_q;
endmodule
